fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_i  in  1  synchronous, active-high reset.
REQ-004 stall_i  in  1  decode not accepting; current output held.
REQ-005 redirect_i  in  1  branch/jump taken; squash fetch path.
REQ-006 redirect_pc_i  in  32  redirect target.
REQ-007 imem_req_o  out  1  instruction-memory request.
REQ-008 imem_addr_o  out  32  request address, word-aligned.
REQ-009 imem_ready_i  in  1  memory accepts request when high with imem_req_o.
REQ-010 imem_rvalid_i  in  1  response valid, at least 1 cycle after acceptance.
REQ-011 imem_rdata_i  in  32  response instruction word.
REQ-012 instr_o  out  32  instruction to the IF/ID register; 32'h0000_0013 (NOP) when valid_o=0.
REQ-013 pc_o  out  32  address of instr_o.
REQ-014 pc_plus4_o  out  32  pc_o+4, modulo 2^32.
REQ-015 valid_o  out  1  instr_o/pc_o hold a real fetched instruction.

Function
REQ-016 States: FETCH (may issue), WAIT (one request outstanding), DROP (outstanding request is squashed).
REQ-017 At most one outstanding request; 2-entry FIFO of {pc, instr}.
REQ-018 imem_req_o=1 iff state FETCH, reset_i=0, and FIFO occupancy <2.
REQ-019 imem_addr_o=pc_q; addr and req stable until imem_ready_i.
REQ-020 On accept (req&&ready): latch req_pc<=pc_q, pc_q<=pc_q+4 (wraps 32'hFFFF_FFFC->0), FETCH->WAIT.
REQ-021 WAIT with imem_rvalid_i: push {req_pc, imem_rdata_i}, go to FETCH; new request issued no earlier than next cycle.
REQ-022 DROP with imem_rvalid_i: discard data, go to FETCH.
REQ-023 imem_rvalid_i in FETCH ignored.
REQ-024 Outputs combinational from FIFO head; valid_o = FIFO not empty.
REQ-025 Pop when valid_o && !stall_i; push and pop same cycle allowed, also when FIFO full.
REQ-026 Redirect (priority over stall and all else): FIFO cleared, pc_q<={redirect_pc_i[31:2],2'b00}, no push that cycle.
REQ-027 Redirect in WAIT without rvalid, or coincident with accept: ->DROP; otherwise ->FETCH.
REQ-028 Redirect in DROP: stay DROP unless rvalid same cycle (->FETCH).
REQ-029 Stall never drops or duplicates an instruction; fetch continues until FIFO full.

Reset
REQ-030 Reset: pc_q=RESET_PC, req_pc=0, FIFO empty, state FETCH.
REQ-031 Outputs during and after reset: valid_o=0, instr_o=NOP, pc_o=0, pc_plus4_o=4, imem_req_o=0.
REQ-032 Reset mid-operation abandons any outstanding request; a later rvalid lands in FETCH and is ignored (REQ-023).

Structure
REQ-033 Shared package: NOP constant 32'h0000_0013, state enum {FETCH,WAIT,DROP}, default RESET_PC.
REQ-034 One sub-module: fetch_fifo (2-entry {pc,instr} FIFO; push, pop, clear, full, empty).

Verification
REQ-035 Reset, ready=1, rvalid 1 cycle after accept, no stall -> addresses 0,4,8 issued; valid_o pulses with pc_o 0,4,8, instr matching memory.
REQ-036 stall_i held 5 cycles after first instruction -> FIFO fills (pc 0,4), req drops; release -> pc_o 0 then 4 then 8, no gaps, no repeats.
REQ-037 redirect_i with target 0x100 while request to 0x8 outstanding -> 0x8 data discarded; next valid_o shows pc_o=0x100.
REQ-038 redirect_pc_i=0x203 -> fetch address 0x200.
REQ-039 RESET_PC=0xFFFF_FFFC -> pc_o 0xFFFF_FFFC with pc_plus4_o 0, then pc_o 0.
REQ-040 reset_i asserted in WAIT, rvalid next cycle -> data ignored, valid_o=0, first fetch RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface fetch_unit_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Two-entry {pc, instr} buffer between instruction memory and decode.
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset_i,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    always_ff @(posedge clk) begin
        if (reset_i || clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Push while full is only legal alongside a pop; it reuses the slot being popped.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, 2-deep output buffer, redirect squash.
//   state | meaning
//   FETCH | may issue a request at pc_q
//   WAIT  | one request outstanding, response will be buffered
//   DROP  | one request outstanding, response will be discarded
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic         stall_i,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_pc_i,
    fetch_unit_if.master imem,
    output logic [31:0]  instr_o,
    output logic [31:0]  pc_o,
    output logic [31:0]  pc_plus4_o,
    output logic         valid_o
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc_q;
    logic         req;
    logic         accept;
    logic         push;
    logic         pop;
    logic         clear;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t head;
    fetch_entry_t din;

    assign accept = req && imem.imem_ready_i;

    always_ff @(posedge clk) begin
        if (reset_i) state_q <= FETCH;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: if (accept) state_d = redirect_i ? DROP : WAIT;
            WAIT: begin
                if (imem.imem_rvalid_i) state_d = FETCH;
                else if (redirect_i)    state_d = DROP;
            end
            DROP: if (imem.imem_rvalid_i) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        req   = (state_q == FETCH) && !reset_i && !fifo_full;
        push  = (state_q == WAIT) && imem.imem_rvalid_i && !redirect_i;
        clear = redirect_i;
        pop   = valid_o && !stall_i && !redirect_i;
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            if (redirect_i)  pc_q <= {redirect_pc_i[31:2], 2'b00};
            else if (accept) pc_q <= pc_q + 32'd4;
            if (accept) req_pc_q <= pc_q;
        end
    end

    assign din = '{pc: req_pc_q, instr: imem.imem_rdata_i};

    fetch_fifo u_fifo (
        .clk     (clk),
        .reset_i (reset_i),
        .push    (push),
        .pop     (pop),
        .clear   (clear),
        .din     (din),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = pc_q;

    assign valid_o    = !fifo_empty && !reset_i;
    assign instr_o    = valid_o ? head.instr : NOP_INSTR;
    assign pc_o       = valid_o ? head.pc : 32'd0;
    assign pc_plus4_o = pc_o + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases, memory responder, decoupled output monitor.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;

    logic        rst_w;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic        w_valid;

    fetch_unit_if bus ();
    fetch_unit_if wbus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (bus),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .valid_o       (valid_o)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk           (clk),
        .reset_i       (rst_w),
        .stall_i       (1'b0),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0000_0000),
        .imem          (wbus),
        .instr_o       (w_instr),
        .pc_o          (w_pc),
        .pc_plus4_o    (w_pc4),
        .valid_o       (w_valid)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int vectors    = 0;
    int miscompares = 0;
    int budget     = 0;
    int lat        = 1;
    int acc_cnt    = 0;
    int cyc        = 0;

    pend_t        pend_q[$];
    logic [31:0]  exp_addr_q[$];
    fetch_entry_t sb_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1000_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: ready while budget remains, responds lat cycles after each accept.
    initial begin
        pend_t       p;
        logic [31:0] ea;
        bus.imem_ready_i  = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.imem_rvalid_i = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end
            bus.imem_ready_i = (budget > 0);
            if (bus.imem_req_o && bus.imem_ready_i) begin
                vectors++;
                if (exp_addr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL req_addr: got unexpected request %h, required none", bus.imem_addr_o);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (bus.imem_addr_o !== ea) begin
                        miscompares++;
                        $display("FAIL req_addr: got %h, required %h", bus.imem_addr_o, ea);
                    end
                end
                p.addr = bus.imem_addr_o;
                p.due  = cyc + lat;
                pend_q.push_back(p);
                budget--;
                acc_cnt++;
            end
        end
    end

    // Output monitor: every consumed instruction is matched against the scoreboard.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (!reset_i && valid_o && !stall_i && !redirect_i) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL out_unexpected: got pc=%h instr=%h, required no output", pc_o, instr_o);
                end else begin
                    e = sb_q.pop_front();
                    if (pc_o !== e.pc || instr_o !== e.instr || pc_plus4_o !== e.pc + 32'd4) begin
                        miscompares++;
                        $display("FAIL out_entry: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                                 pc_o, instr_o, pc_plus4_o, e.pc, e.instr, e.pc + 32'd4);
                    end
                end
            end
        end
    end

    // Wrap instance responder: always ready, data one cycle after accept.
    logic        w_pend = 1'b0;
    logic [31:0] w_addr = 32'h0;
    initial begin
        wbus.imem_ready_i  = 1'b1;
        wbus.imem_rvalid_i = 1'b0;
        wbus.imem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            wbus.imem_rvalid_i = w_pend;
            wbus.imem_rdata_i  = mem_word(w_addr);
            w_pend = wbus.imem_req_o;
            if (wbus.imem_req_o) w_addr = wbus.imem_addr_o;
        end
    end

    task automatic push_exp(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        reset_i    = 1'b1;
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        budget     = 0;
        tick();
        tick();
        acc_cnt = 0;
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        while (acc_cnt < n && k < 60) begin
            tick();
            k++;
        end
        check32("accept_count", acc_cnt, n);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(sb_q.size() == 0 && exp_addr_q.size() == 0 && pend_q.size() == 0) && k < 100) begin
            tick();
            k++;
        end
        check32("idle_pending", sb_q.size() + exp_addr_q.size() + pend_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic wait_w_valid();
        int k = 0;
        while (!w_valid && k < 20) begin
            tick();
            k++;
        end
        check32("wrap_valid", {31'd0, w_valid}, 32'd1);
    endtask

    initial begin
        reset_i       = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        rst_w         = 1'b1;

        // Reset state
        tick();
        tick();
        check32("rst_valid", {31'd0, valid_o}, 32'd0);
        check32("rst_instr", instr_o, 32'h0000_0013);
        check32("rst_pc", pc_o, 32'h0);
        check32("rst_pc4", pc_plus4_o, 32'h4);
        check32("rst_req", {31'd0, bus.imem_req_o}, 32'd0);

        // Streaming fetch, no stall
        do_reset();
        lat = 1;
        exp_addr_q = '{32'h0, 32'h4, 32'h8};
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        budget  = 3;
        reset_i = 1'b0;
        wait_idle();

        // Stall fills the buffer, then drains in order
        do_reset();
        lat = 1;
        exp_addr_q = '{32'h0, 32'h4, 32'h8};
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        budget  = 3;
        reset_i = 1'b0;
        begin
            int k = 0;
            while (!valid_o && k < 20) begin
                tick();
                k++;
            end
        end
        stall_i = 1'b1;
        repeat (5) tick();
        check32("stall_req_low", {31'd0, bus.imem_req_o}, 32'd0);
        check32("stall_hold_pc", pc_o, 32'h0);
        stall_i = 1'b0;
        tick();
        check32("drain_no_gap", {31'd0, valid_o}, 32'd1);
        wait_idle();

        // Redirect while request to 0x8 is outstanding
        do_reset();
        lat = 3;
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'h100};
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h100);
        budget  = 4;
        reset_i = 1'b0;
        wait_acc(3);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        tick();
        redirect_i = 1'b0;
        check32("redir_valid", {31'd0, valid_o}, 32'd0);
        wait_idle();

        // Unaligned redirect target
        do_reset();
        lat = 1;
        reset_i = 1'b0;
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h203;
        tick();
        redirect_i = 1'b0;
        check32("align_addr", bus.imem_addr_o, 32'h200);
        check32("align_req", {31'd0, bus.imem_req_o}, 32'd1);
        exp_addr_q = '{32'h200};
        push_exp(32'h200);
        budget = 1;
        wait_idle();

        // Reset while a request is outstanding
        do_reset();
        lat = 2;
        exp_addr_q = '{32'h0, 32'h0};
        push_exp(32'h0);
        budget  = 2;
        reset_i = 1'b0;
        wait_acc(1);
        reset_i = 1'b1;
        check32("wait_rst_req", {31'd0, bus.imem_req_o}, 32'd0);
        tick();
        reset_i = 1'b0;
        tick();
        check32("stale_ignored", {31'd0, valid_o}, 32'd0);
        wait_idle();

        // Wrap of the fetch address
        rst_w = 1'b0;
        wait_w_valid();
        check32("wrap_pc", w_pc, 32'hFFFF_FFFC);
        check32("wrap_pc4", w_pc4, 32'h0);
        check32("wrap_instr", w_instr, 32'h0FFF_FFFC);
        tick();
        wait_w_valid();
        check32("wrap_pc_next", w_pc, 32'h0);
        check32("wrap_pc4_next", w_pc4, 32'h4);
        check32("wrap_instr_next", w_instr, 32'h1000_0000);
        rst_w = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
